uc_bus_master: RTL and testbench

- Drives the microcontroller side of the cartridge's parallel SRAM access bus.
- Signals driven: uc_data, uc_read, uc_write, set_addr_lo, set_addr_hi, strobe_addr, with uc_ack returned from the cartridge logic.
- Converts single-word commands (set address, write byte, read byte) from a host-side valid/ready interface into correctly sequenced bus handshakes.
- Used in the bench/host-adapter FPGA and as the golden initiator for cartridge bring-up.

---
 rtl/uc_bus_master_if.sv | 36 +++
 rtl/uc_bus_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_uc_bus_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uc_bus_master_if.sv
// Host command/response and cartridge SRAM bus signals for uc_bus_master.
interface uc_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  uc_data_o;
  logic        uc_data_oe;
  logic [7:0]  uc_data_i;
  logic        uc_read;
  logic        uc_write;
  logic        set_addr_lo;
  logic        set_addr_hi;
  logic        strobe_addr;
  logic        uc_ack;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  uc_data_i, uc_ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output uc_data_o, uc_data_oe, uc_read, uc_write,
    output set_addr_lo, set_addr_hi, strobe_addr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output uc_data_i, uc_ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  uc_data_o, uc_data_oe, uc_read, uc_write,
    input  set_addr_lo, set_addr_hi, strobe_addr
  );
endinterface

// File: rtl/uc_bus_master.sv
// Sequences host commands into cartridge SRAM bus handshakes.
// Optional UC_ADDR_CACHE_EN skips address phases on a shadow-address hit.
module uc_bus_master #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic        clk,
  input logic        reset_n,
  uc_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ALO, AHI, REQ, REL, INC, RESP
  } state_e;

  localparam logic [3:0] PH_ADDR_END = 4'(SETUP_CYCLES + STROBE_CYCLES);
  localparam logic [3:0] PH_SETUP    = 4'(SETUP_CYCLES);
  localparam logic [3:0] PH_STROBE   = 4'(STROBE_CYCLES);
  localparam logic [9:0] TMO_END     = 10'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  ph_q, ph_d;
  logic [9:0]  tmo_q, tmo_d, tmo_inc;
  logic        seen_q, seen_d;
  logic [1:0]  op_q, op_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [14:0] shadow_q, shadow_d;
  logic        shv_q, shv_d;
  logic        ack_s1_q, ack_s2_q;

  logic       rdy_q, rdy_d, rv_q, rv_d, re_q, re_d;
  logic [7:0] do_q, do_d;
  logic       oe_q, oe_d, rd_q, rd_d, wr_q, wr_d;
  logic       lo_q, lo_d, hi_q, hi_d, stb_q, stb_d;

  assign tmo_inc = tmo_q + 10'd1;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    tmo_d    = '0;
    seen_d   = seen_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    shv_d    = shv_q;
    unique case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d    = bus.cmd_op;
        addr_d  = bus.cmd_addr;
        wdata_d = bus.cmd_wdata;
        err_d   = 1'b0;
        ph_d    = '0;
        if (bus.cmd_op == 2'b11) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
`ifdef UC_ADDR_CACHE_EN
        else if (bus.cmd_op != 2'b00 && shv_q &&
                 bus.cmd_addr == shadow_q) begin
          state_d = REQ;
          seen_d  = !ack_s2_q;
        end
`endif
        else begin
          state_d = ALO;
        end
      end
      ALO: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == PH_ADDR_END) begin
          ph_d    = '0;
          state_d = AHI;
        end
      end
      AHI: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == PH_ADDR_END) begin
          ph_d     = '0;
          shadow_d = addr_q;
          shv_d    = 1'b1;
          if (op_q == 2'b00) begin
            state_d = RESP;
          end else begin
            state_d = REQ;
            seen_d  = !ack_s2_q;
          end
        end
      end
      // a stale high ack must drop before it can complete the request
      REQ: begin
        if (!ack_s2_q) seen_d = 1'b1;
        if (ack_s2_q && seen_q) begin
          if (op_q == 2'b10) rdata_d = bus.uc_data_i;
          ph_d    = '0;
          state_d = REL;
        end else if (tmo_inc == TMO_END) begin
          err_d   = 1'b1;
          shv_d   = 1'b0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      REL: begin
        if (!ack_s2_q) begin
          ph_d    = '0;
          state_d = INC;
        end else if (tmo_inc == TMO_END) begin
          err_d   = 1'b1;
          shv_d   = 1'b0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_inc;
          ph_d  = 4'd1;
        end
      end
      INC: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == PH_STROBE) begin
          ph_d     = '0;
          shadow_d = shadow_q + 15'd1;
          state_d  = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_d = (state_d == IDLE);
    rv_d  = 1'b0;
    re_d  = 1'b0;
    do_d  = '0;
    oe_d  = 1'b0;
    rd_d  = 1'b0;
    wr_d  = 1'b0;
    lo_d  = 1'b0;
    hi_d  = 1'b0;
    stb_d = 1'b0;
    unique case (state_d)
      ALO, AHI: begin
        oe_d  = 1'b1;
        lo_d  = (state_d == ALO);
        hi_d  = (state_d == AHI);
        do_d  = (state_d == ALO) ? addr_d[7:0]
                                 : {1'b0, addr_d[14:8]};
        stb_d = (ph_d >= PH_SETUP) && (ph_d < PH_ADDR_END);
      end
      REQ: begin
        if (op_d == 2'b01) begin
          oe_d = 1'b1;
          do_d = wdata_d;
          wr_d = 1'b1;
        end else begin
          rd_d = 1'b1;
        end
      end
      REL: if (op_d == 2'b01 && ph_d == 4'd0) begin
        oe_d = 1'b1;
        do_d = wdata_d;
      end
      INC:  stb_d = (ph_d < PH_STROBE);
      RESP: begin
        rv_d = 1'b1;
        re_d = err_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      tmo_q    <= '0;
      seen_q   <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      shadow_q <= '0;
      shv_q    <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      rdy_q    <= 1'b0;
      rv_q     <= 1'b0;
      re_q     <= 1'b0;
      do_q     <= '0;
      oe_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      lo_q     <= 1'b0;
      hi_q     <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      shadow_q <= shadow_d;
      shv_q    <= shv_d;
      ack_s1_q <= bus.uc_ack;
      ack_s2_q <= ack_s1_q;
      rdy_q    <= rdy_d;
      rv_q     <= rv_d;
      re_q     <= re_d;
      do_q     <= do_d;
      oe_q     <= oe_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      stb_q    <= stb_d;
    end
  end

  assign bus.cmd_ready   = rdy_q;
  assign bus.rsp_valid   = rv_q;
  assign bus.rsp_err     = re_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.uc_data_o   = do_q;
  assign bus.uc_data_oe  = oe_q;
  assign bus.uc_read     = rd_q;
  assign bus.uc_write    = wr_q;
  assign bus.set_addr_lo = lo_q;
  assign bus.set_addr_hi = hi_q;
  assign bus.strobe_addr = stb_q;

endmodule

// File: tb/tb_uc_bus_master.sv
// Directed bench for uc_bus_master with a delayed-ack cartridge responder.
module tb_uc_bus_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uc_bus_master_if bus ();

  uc_bus_master dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  int rsp_delay = 7;
  bit rsp_never = 1'b0;
  int rcnt = 0;

  always @(posedge clk) begin
    if (!rsp_never && (bus.uc_write === 1'b1 || bus.uc_read === 1'b1)) begin
      if (rcnt >= rsp_delay) bus.uc_ack <= 1'b1;
      else rcnt = rcnt + 1;
    end else begin
      rcnt = 0;
      bus.uc_ack <= 1'b0;
    end
  end

  int n_lo, n_hi, n_inc, n_rsp, wr_cycles, lat, viol, wd_bad;
  logic [7:0] lo_data, hi_data, got_rdata;
  logic got_err, prev_stb, timed_out;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [14:0] a,
                         input logic [7:0] d, input int budget);
    bit done;
    int extra;
    n_lo = 0; n_hi = 0; n_inc = 0; n_rsp = 0; wr_cycles = 0;
    lat = 0; viol = 0; wd_bad = 0; lo_data = '0; hi_data = '0;
    got_rdata = '0; got_err = 1'b0; prev_stb = 1'b0;
    timed_out = 1'b0; done = 1'b0; extra = 0;
    @(negedge clk);
    for (int w = 0; w < 20 && bus.cmd_ready !== 1'b1; w++) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int c = 1; c <= budget && extra < 3; c++) begin
      @(negedge clk);
      if (bus.strobe_addr && !prev_stb) begin
        if (bus.set_addr_lo) begin n_lo++; lo_data = bus.uc_data_o; end
        else if (bus.set_addr_hi) begin n_hi++; hi_data = bus.uc_data_o; end
        else n_inc++;
      end
      prev_stb = bus.strobe_addr;
      if (bus.uc_read && bus.uc_write) viol++;
      if (bus.strobe_addr && (bus.uc_read || bus.uc_write)) viol++;
      if (bus.uc_read && bus.uc_data_oe) viol++;
      if (bus.uc_write) begin
        wr_cycles++;
        if (bus.uc_data_o !== d || !bus.uc_data_oe) wd_bad++;
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        if (!done) begin
          lat = c;
          got_err = bus.rsp_err;
          got_rdata = bus.rsp_rdata;
        end
        done = 1'b1;
      end
      if (done) extra++;
    end
    if (!done) timed_out = 1'b1;
  endtask

  int exp_sel;
  int rv_cnt;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.uc_data_i = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_oe", bus.uc_data_oe, 0);
    chk("rst_strobe", bus.strobe_addr, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", bus.cmd_ready, 1);

    rsp_delay = 7;
    run_cmd(2'b01, 15'h1234, 8'hA5, 200);
    chk("wr_timeout", timed_out, 0);
    chk("wr_lo_cnt", n_lo, 1);
    chk("wr_lo_data", lo_data, 8'h34);
    chk("wr_hi_cnt", n_hi, 1);
    chk("wr_hi_data", hi_data, 8'h12);
    chk("wr_write_seen", wr_cycles > 0, 1);
    chk("wr_data_bus", wd_bad, 0);
    chk("wr_inc_cnt", n_inc, 1);
    chk("wr_rsp_cnt", n_rsp, 1);
    chk("wr_err", got_err, 0);
    chk("wr_viol", viol, 0);

    bus.uc_data_i = 8'h5C;
    rsp_delay = 4;
    run_cmd(2'b10, 15'h7FFF, 8'h00, 200);
    chk("rd_timeout", timed_out, 0);
    chk("rd_rdata", got_rdata, 8'h5C);
    chk("rd_err", got_err, 0);
    chk("rd_hi_data", hi_data, 8'h7F);
    chk("rd_viol", viol, 0);
    chk("rd_wrap_shadow", dut.shadow_q, 15'h0000);
    chk("rd_shadow_valid", dut.shv_q, 1);

`ifdef UC_ADDR_CACHE_EN
    exp_sel = 0;
`else
    exp_sel = 2;
`endif
    run_cmd(2'b01, 15'h0100, 8'h3C, 200);
    chk("c1_sel", n_lo + n_hi, 2);
    chk("c1_rsp", n_rsp, 1);
    run_cmd(2'b10, 15'h0101, 8'h00, 200);
    chk("c2_sel", n_lo + n_hi, exp_sel);
    chk("c2_rsp", n_rsp, 1);
    chk("c2_inc", n_inc, 1);
    chk("c2_rdata", got_rdata, 8'h5C);

    rsp_never = 1'b1;
    run_cmd(2'b01, 15'h0200, 8'h77, 1300);
    chk("to_rsp", n_rsp, 1);
    chk("to_err", got_err, 1);
    chk("to_wr_cycles", wr_cycles, 1023);
    chk("to_write_low", bus.uc_write, 0);
    chk("to_oe_low", bus.uc_data_oe, 0);
    chk("to_rdata_kept", got_rdata, 8'h5C);
    rsp_never = 1'b0;
    run_cmd(2'b01, 15'h0200, 8'h77, 200);
    chk("to_resend_lo", n_lo, 1);
    chk("to_resend_hi", n_hi, 1);
    chk("to_resend_err", got_err, 0);

    rsp_never = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_addr  = 15'h0555;
    bus.cmd_wdata = 8'h11;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int c = 0; c < 40 && bus.uc_write !== 1'b1; c++) @(negedge clk);
    chk("rq_reached_req", bus.uc_write, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rq_rst_write", bus.uc_write, 0);
    chk("rq_rst_oe", bus.uc_data_oe, 0);
    chk("rq_rst_data", bus.uc_data_o, 0);
    chk("rq_rst_rv", bus.rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk("rq_ready_after", bus.cmd_ready, 1);
    rv_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) rv_cnt++;
    end
    chk("rq_no_rsp", rv_cnt, 0);
    rsp_never = 1'b0;

    run_cmd(2'b11, 15'h0123, 8'h00, 20);
    chk("op11_rsp", n_rsp, 1);
    chk("op11_err", got_err, 1);
    chk("op11_lat", lat, 1);
    chk("op11_sel", n_lo + n_hi + n_inc, 0);
    chk("op11_wr", wr_cycles, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
